// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_access_unit                                              |
// | Description : MEM-stage responder. Decodes the EX/MEM word, runs loads and |
// |               stores on a req/gnt/rvalid data bus, stalls the pipeline     |
// |               until the access retires and owns the MEM/WB register.       |
// | Option      : MEM_TIMEOUT_EN - abort a bus access after TIMEOUT_CYCLES     |
// |               cycles in REQ+WAIT (param TIMEOUT_CYCLES exists only then).  |
// | Ports       : clk, rst_n (async, active low)                               |
// |               ex_mem/ex_mem_valid   - EX/MEM word in                       |
// |               stall                 - comb hold for upstream registers     |
// |               mem_wb                - registered MEM/WB word               |
// |               misalign/timeout      - registered 1-cycle error pulses      |
// |               dmem_req/we/addr/wdata, dmem_gnt/rvalid/rdata - data bus     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package mem_access_pkg;
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        MemToReg;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [4:0]  rd;
    logic        RegWrite;
    logic        MemToReg;
  } mem_wb_t;
endpackage

module mem_access_unit
  import mem_access_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  ex_mem_t     ex_mem,
  input  logic        ex_mem_valid,
  output logic        stall,
  output mem_wb_t     mem_wb,
  output logic        misalign,
  output logic        timeout,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic        m2r_q, m2r_d;
  mem_wb_t     mem_wb_q, mem_wb_d;
  logic        misalign_q, misalign_d;

  logic mem_op;
  logic aligned;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Read+Write together is decoded as a load, so only a pure write is a store.
  assign mem_op  = ex_mem_valid & (ex_mem.MemRead | ex_mem.MemWrite);
  assign aligned = (ex_mem.alu_result[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    rw_d       = rw_q;
    m2r_d      = m2r_q;
    mem_wb_d   = '0;      // anything that does not retire leaves a bubble
    misalign_d = 1'b0;
    stall      = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          if (aligned) begin
            stall   = 1'b1;
            req_d   = 1'b1;
            we_d    = ex_mem.MemWrite & ~ex_mem.MemRead;
            addr_d  = {ex_mem.alu_result[31:2], 2'b00};
            wdata_d = ex_mem.rs2_data;
            rd_d    = ex_mem.rd;
            rw_d    = ex_mem.RegWrite;
            m2r_d   = ex_mem.MemToReg;
            state_d = ST_REQ;
`ifdef MEM_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            // Misaligned access is dropped; the pipeline keeps moving.
            misalign_d = 1'b1;
          end
        end else if (ex_mem_valid) begin
          mem_wb_d.alu_result = ex_mem.alu_result;
          mem_wb_d.rd         = ex_mem.rd;
          mem_wb_d.RegWrite   = ex_mem.RegWrite;
          mem_wb_d.MemToReg   = ex_mem.MemToReg;
        end
      end

      ST_REQ: begin
        stall = 1'b1;
        if (dmem_gnt) begin
          req_d = 1'b0;
          if (we_q) begin
            // Store retires on grant; it never writes the register file.
            mem_wb_d.alu_result = addr_q;
            mem_wb_d.rd         = rd_q;
            mem_wb_d.RegWrite   = 1'b0;
            mem_wb_d.MemToReg   = m2r_q;
            stall               = 1'b0;
            state_d             = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        stall = 1'b1;
        if (dmem_rvalid) begin
          mem_wb_d.alu_result = addr_q;
          mem_wb_d.mem_data   = dmem_rdata;
          mem_wb_d.rd         = rd_q;
          mem_wb_d.RegWrite   = rw_q;
          mem_wb_d.MemToReg   = m2r_q;
          stall               = 1'b0;
          state_d             = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase

`ifdef MEM_TIMEOUT_EN
    // Only a cycle that stays busy counts toward the abort; completion wins.
    if ((state_q != ST_IDLE) && (state_d != ST_IDLE)) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        req_d     = 1'b0;
        timeout_d = 1'b1;
        mem_wb_d  = '0;
        stall     = 1'b0;
        state_d   = ST_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      m2r_q      <= 1'b0;
      mem_wb_q   <= '0;
      misalign_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      rw_q       <= rw_d;
      m2r_q      <= m2r_d;
      mem_wb_q   <= mem_wb_d;
      misalign_q <= misalign_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign mem_wb     = mem_wb_q;
  assign misalign   = misalign_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
`ifdef MEM_TIMEOUT_EN
  assign timeout    = timeout_q;
`else
  assign timeout    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_access_unit                                           |
// | Description : Self-checking bench for mem_access_unit: vector table for    |
// |               single-cycle cases, directed bus sequences, and a random     |
// |               instruction stream against a transaction-level model.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clk;
  logic        rst_n;
  ex_mem_t     ex_mem;
  logic        ex_mem_valid;
  logic        stall;
  mem_wb_t     mem_wb;
  logic        misalign;
  logic        timeout;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

`ifdef MEM_TIMEOUT_EN
  mem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
`else
  mem_access_unit dut (
`endif
    .clk(clk), .rst_n(rst_n), .ex_mem(ex_mem), .ex_mem_valid(ex_mem_valid),
    .stall(stall), .mem_wb(mem_wb), .misalign(misalign), .timeout(timeout),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic    v;
    ex_mem_t em;
    logic    exp_stall;
    mem_wb_t exp_wb;
    logic    exp_mis;
  } vec_t;

  vec_t vecs[7];

  function automatic ex_mem_t mk(input logic [31:0] alu, input logic [31:0] rs2,
                                 input logic [4:0] rd, input logic rw,
                                 input logic mr, input logic mw, input logic m2r);
    ex_mem_t e;
    e.alu_result = alu; e.rs2_data = rs2; e.rd = rd; e.RegWrite = rw;
    e.MemRead = mr; e.MemWrite = mw; e.MemToReg = m2r;
    return e;
  endfunction

  function automatic mem_wb_t mkwb(input logic [31:0] alu, input logic [31:0] data,
                                   input logic [4:0] rd, input logic rw, input logic m2r);
    mem_wb_t w;
    w.alu_result = alu; w.mem_data = data; w.rd = rd; w.RegWrite = rw; w.MemToReg = m2r;
    return w;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input ex_mem_t em, input logic g,
                       input logic rv, input logic [31:0] rd);
    ex_mem_valid = v; ex_mem = em; dmem_gnt = g; dmem_rvalid = rv; dmem_rdata = rd;
  endtask

  // Advance one clock; return 1 ns after the edge so registered outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  ex_mem_t em;
  ex_mem_t nop;

  // random-stream model state
  ex_mem_t cur;
  logic    cur_v;
  int      age;
  logic    granted;
  logic    adv;
  logic    is_mem, is_al, is_st;
  logic    exp_req, exp_stall, exp_mis;
  mem_wb_t exp_wb;
  logic    g, rv;
  logic [31:0] rdat, r;

  initial begin
    nop = mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[0] = '{1'b1, mk(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0,
                mkwb(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0), 1'b0};
    vecs[1] = '{1'b0, mk(32'h2000, 32'h55, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1), 1'b0,
                mkwb(32'h0, 32'h0, 5'd0, 1'b0, 1'b0), 1'b0};
    vecs[2] = '{1'b1, mk(32'h103, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1), 1'b0,
                mkwb(32'h0, 32'h0, 5'd0, 1'b0, 1'b0), 1'b1};
    vecs[3] = '{1'b1, mk(32'h202, 32'h77, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0,
                mkwb(32'h0, 32'h0, 5'd0, 1'b0, 1'b0), 1'b1};
    vecs[4] = '{1'b1, mk(32'hFFFF_FFFF, 32'h1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1), 1'b0,
                mkwb(32'hFFFF_FFFF, 32'h0, 5'd0, 1'b1, 1'b1), 1'b0};
    vecs[5] = '{1'b1, mk(32'hABCD_0001, 32'h9, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0,
                mkwb(32'hABCD_0001, 32'h0, 5'd31, 1'b0, 1'b0), 1'b0};
    vecs[6] = '{1'b1, mk(32'h1, 32'h0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1), 1'b0,
                mkwb(32'h0, 32'h0, 5'd0, 1'b0, 1'b0), 1'b1};

    // ---------------- reset ----------------
    rst_n = 1'b0;
    drive(1'b0, nop, 1'b0, 1'b0, 32'h0);
    @(posedge clk); step();
    chk("rst_mem_wb", mem_wb, '0);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_we", dmem_we, 1'b0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_misalign", misalign, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_stall", stall, 1'b0);
    rst_n = 1'b1;
    step();

    // ---------------- single-cycle vector table ----------------
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].v, vecs[i].em, 1'b0, 1'b0, 32'h0);
      #1;
      chk($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
      chk($sformatf("vec%0d_req_before", i), dmem_req, 1'b0);
      step();
      chk($sformatf("vec%0d_mem_wb", i), mem_wb, vecs[i].exp_wb);
      chk($sformatf("vec%0d_misalign", i), misalign, vecs[i].exp_mis);
      chk($sformatf("vec%0d_req", i), dmem_req, 1'b0);
    end
    drive(1'b0, nop, 1'b0, 1'b0, 32'h0);
    step();
    chk("vec_misalign_clears", misalign, 1'b0);

    // ---------------- load: gnt on 3rd REQ cycle, rvalid 2 later ----------------
    em = mk(32'h100, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, em, 1'b0, 1'b0, 32'h0);
    #1; chk("ld_stall_accept", stall, 1'b1);
    step();
    chk("ld_req", dmem_req, 1'b1);
    chk("ld_addr", dmem_addr, 32'h100);
    chk("ld_we", dmem_we, 1'b0);
    chk("ld_wb_accept", mem_wb, '0);
    for (int i = 0; i < 3; i++) begin
      // rvalid during the grant cycle must be ignored
      drive(1'b1, em, (i == 2), (i == 2), 32'h1111_1111);
      #1; chk($sformatf("ld_stall_req%0d", i), stall, 1'b1);
      step();
      chk($sformatf("ld_wb_req%0d", i), mem_wb, '0);
      chk($sformatf("ld_req%0d", i), dmem_req, (i < 2));
      if (i < 2) chk($sformatf("ld_addr_hold%0d", i), dmem_addr, 32'h100);
    end
    drive(1'b1, em, 1'b0, 1'b0, 32'h0);
    #1; chk("ld_stall_wait", stall, 1'b1);
    step();
    chk("ld_wb_wait", mem_wb, '0);
    drive(1'b1, em, 1'b0, 1'b1, 32'hCAFE_F00D);
    #1; chk("ld_stall_rvalid", stall, 1'b0);
    step();
    chk("ld_wb_done", mem_wb, mkwb(32'h100, 32'hCAFE_F00D, 5'd9, 1'b1, 1'b1));
    drive(1'b0, nop, 1'b0, 1'b1, 32'h0);
    #1; chk("ld_stray_rvalid_stall", stall, 1'b0);
    step();
    chk("ld_wb_bubble", mem_wb, '0);

    // ---------------- store: gnt already high when req rises ----------------
    em = mk(32'h204, 32'hDEAD_BEEF, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, em, 1'b1, 1'b0, 32'h0);
    #1; chk("st_stall_accept", stall, 1'b1);
    step();
    chk("st_req", dmem_req, 1'b1);
    chk("st_we", dmem_we, 1'b1);
    chk("st_addr", dmem_addr, 32'h204);
    chk("st_wdata", dmem_wdata, 32'hDEAD_BEEF);
    chk("st_wb_accept", mem_wb, '0);
    drive(1'b1, em, 1'b1, 1'b0, 32'h0);
    #1; chk("st_stall_gnt", stall, 1'b0);
    step();
    chk("st_req_drop", dmem_req, 1'b0);
    chk("st_wb_done", mem_wb, mkwb(32'h204, 32'h0, 5'd6, 1'b0, 1'b0));
    drive(1'b0, nop, 1'b0, 1'b0, 32'h0);
    step();

    // ---------------- async reset in REQ and in WAIT ----------------
    em = mk(32'h300, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, em, 1'b0, 1'b0, 32'h0);
    step();
    chk("rstreq_req_up", dmem_req, 1'b1);
    drive(1'b0, nop, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rstreq_req_drop", dmem_req, 1'b0);
    chk("rstreq_wb", mem_wb, '0);
    rst_n = 1'b1;
    step();
    drive(1'b1, em, 1'b0, 1'b0, 32'h0);
    step();
    drive(1'b1, em, 1'b1, 1'b0, 32'h0);
    step();
    drive(1'b1, em, 1'b0, 1'b0, 32'h0);
    #1;
    chk("rstwait_stall_before", stall, 1'b1);
    drive(1'b0, nop, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    drive(1'b0, nop, 1'b0, 1'b1, 32'h5555_AAAA);
    #1;
    chk("rstwait_stall", stall, 1'b0);
    chk("rstwait_req", dmem_req, 1'b0);
    step();
    chk("rstwait_wb_late_rvalid", mem_wb, '0);
    drive(1'b0, nop, 1'b0, 1'b0, 32'h0);
    step();

`ifdef MEM_TIMEOUT_EN
    // ---------------- timeout: grant never arrives ----------------
    em = mk(32'h40, 32'h5, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, em, 1'b0, 1'b0, 32'h0);
    step();
    for (int k = 1; k <= 7; k++) begin
      #1; chk($sformatf("to_stall%0d", k), stall, 1'b1);
      step();
      chk($sformatf("to_pulse_early%0d", k), timeout, 1'b0);
    end
    #1; chk("to_stall_release", stall, 1'b0);
    step();
    chk("to_pulse", timeout, 1'b1);
    chk("to_req_drop", dmem_req, 1'b0);
    chk("to_wb", mem_wb, '0);
    drive(1'b0, nop, 1'b0, 1'b0, 32'h0);
    step();
    chk("to_pulse_clear", timeout, 1'b0);
`endif

    // ---------------- random instruction stream ----------------
    adv = 1'b1;
    cur = nop; cur_v = 1'b0; age = 0; granted = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (adv) begin
        r = $urandom;
        cur_v = (r[2:0] != 3'd0);
        cur.alu_result = $urandom;
        if (r[6:4] != 3'd0) cur.alu_result[1:0] = 2'b00;
        cur.rs2_data = $urandom;
        cur.rd       = r[12:8];
        cur.RegWrite = r[13];
        cur.MemToReg = r[14];
        case (r[17:16])
          2'd0: begin cur.MemRead = 1'b0; cur.MemWrite = 1'b0; end
          2'd1: begin cur.MemRead = 1'b1; cur.MemWrite = 1'b0; end
          2'd2: begin cur.MemRead = 1'b0; cur.MemWrite = 1'b1; end
          default: begin cur.MemRead = 1'b1; cur.MemWrite = 1'b1; end
        endcase
        age = 0; granted = 1'b0;
      end else begin
        age++;
      end
      is_mem = cur_v & (cur.MemRead | cur.MemWrite);
      is_al  = (cur.alu_result[1:0] == 2'b00);
      is_st  = cur.MemWrite & ~cur.MemRead;

      // A request is outstanding from the cycle after acceptance until granted.
      exp_req = is_mem & is_al & (age >= 1) & ~granted;
      chk("rnd_req", dmem_req, exp_req);
      if (exp_req) begin
        chk("rnd_addr", dmem_addr, cur.alu_result);
        chk("rnd_we", dmem_we, is_st);
        if (is_st) chk("rnd_wdata", dmem_wdata, cur.rs2_data);
      end

      r = $urandom;
      if (exp_req) g = r[0] | (age >= 4);
      else         g = (r[1:0] == 2'd0);
      if (granted) rv = r[4] | (age >= 7);
      else         rv = (r[6:5] == 2'd0);
      rdat = $urandom;
      drive(cur_v, cur, g, rv, rdat);
      #1;

      exp_mis = 1'b0;
      exp_wb  = '0;
      if (!cur_v) begin
        exp_stall = 1'b0;
      end else if (!is_mem) begin
        exp_stall = 1'b0;
        exp_wb = mkwb(cur.alu_result, 32'h0, cur.rd, cur.RegWrite, cur.MemToReg);
      end else if (!is_al) begin
        exp_stall = 1'b0;
        exp_mis   = 1'b1;
      end else if (exp_req && g && is_st) begin
        exp_stall = 1'b0;
        exp_wb = mkwb(cur.alu_result, 32'h0, cur.rd, 1'b0, cur.MemToReg);
      end else if (granted && rv) begin
        exp_stall = 1'b0;
        exp_wb = mkwb(cur.alu_result, rdat, cur.rd, cur.RegWrite, cur.MemToReg);
      end else begin
        exp_stall = 1'b1;
      end
      if (exp_req && g && !is_st) granted = 1'b1;

      chk("rnd_stall", stall, exp_stall);
      step();
      chk("rnd_mem_wb", mem_wb, exp_wb);
      chk("rnd_misalign", misalign, exp_mis);
      chk("rnd_timeout", timeout, 1'b0);
      adv = ~exp_stall;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
